// File: rtl/pc_adder_reg16_if.sv
// pc_adder_reg16_if: control and data bundle for the program-counter block.
//
// master modport (front-end control) drives:
//   clr, load, load_data, inc_en, add_b, cin
// and observes:
//   pc (registered PC), next_pc / cout (combinational adder result),
//   wrapped (registered carry flag of the last update)
// slave modport (pc_adder_reg16) is the mirror image.
//
// Parameters:
//   WIDTH - datapath width; every data signal scales with it.

interface pc_adder_reg16_if #(
    parameter int unsigned WIDTH = 16
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             inc_en;
    logic [WIDTH-1:0] add_b;
    logic             cin;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc;
    logic             cout;
    logic             wrapped;

    modport master (
        output clr,
        output load,
        output load_data,
        output inc_en,
        output add_b,
        output cin,
        input  pc,
        input  next_pc,
        input  cout,
        input  wrapped
    );

    modport slave (
        input  clr,
        input  load,
        input  load_data,
        input  inc_en,
        input  add_b,
        input  cin,
        output pc,
        output next_pc,
        output cout,
        output wrapped
    );
endinterface

// File: rtl/pc_adder_reg16.sv
// pc_adder_reg16: program-counter register fed by a ripple-carry adder.
//
// Each enabled cycle the PC advances by add_b + cin; it can also be loaded
// directly (jumps) or cleared. Update priority on the rising clock edge is
// clr > load > inc_en > hold.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (pc = RESET_VAL, wrapped = 0)
//   pc_bus  - pc_adder_reg16_if.slave:
//             clr, load, load_data, inc_en, add_b, cin (inputs)
//             pc, wrapped (registered outputs)
//             next_pc, cout (combinational adder outputs)
//
// Parameters:
//   WIDTH     - datapath width
//   RESET_VAL - value after asynchronous reset and after synchronous clear
//
// Optional build macro:
//   PC_SATURATE_EN - when defined, an increment that carries out sets pc to
//                    all-ones instead of wrapping; wrapped is still set and
//                    next_pc / cout remain the raw adder values.

module pc_adder_reg16 #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_adder_reg16_if.slave        pc_bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrapped_q, wrapped_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] next_pc;
    logic             cout;

    // Ripple-carry adder: one full adder per bit, carry chained LSB to MSB.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = pc_bus.cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i]     = pc_q[i] ^ pc_bus.add_b[i] ^ carry[i];
            carry[i+1] = (pc_q[i] & pc_bus.add_b[i]) |
                         (carry[i] & (pc_q[i] ^ pc_bus.add_b[i]));
        end
    end

    // Disabled adder passes pc through and reports no carry.
    always_comb begin
        next_pc = pc_q;
        cout    = 1'b0;
        if (pc_bus.inc_en) begin
            next_pc = sum;
            cout    = carry[WIDTH];
        end
    end

    always_comb begin
        pc_d      = pc_q;
        wrapped_d = wrapped_q;
        if (pc_bus.clr) begin
            pc_d      = RESET_VAL;
            wrapped_d = 1'b0;
        end else if (pc_bus.load) begin
            pc_d      = pc_bus.load_data;
            wrapped_d = 1'b0;
        end else if (pc_bus.inc_en) begin
`ifdef PC_SATURATE_EN
            pc_d      = cout ? {WIDTH{1'b1}} : next_pc;
`else
            pc_d      = next_pc;
`endif
            wrapped_d = cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VAL;
            wrapped_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign pc_bus.pc      = pc_q;
    assign pc_bus.wrapped = wrapped_q;
    assign pc_bus.next_pc = next_pc;
    assign pc_bus.cout    = cout;

endmodule

// File: tb/tb_pc_adder_reg16.sv
module tb_pc_adder_reg16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pc_adder_reg16_if #(.WIDTH(16)) bus ();

    pc_adder_reg16 #(
        .WIDTH     (16),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pc_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr       = 1'b0;
        bus.load      = 1'b0;
        bus.load_data = 16'h0000;
        bus.inc_en    = 1'b0;
        bus.add_b     = 16'h0000;
        bus.cin       = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (bus.pc !== 16'h0000 || bus.wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: pc=%h wrapped=%b, want pc=0000 wrapped=0",
                     bus.pc, bus.wrapped);
        end
        rst_n         = 1'b1;
        bus.load      = 1'b1;
        bus.load_data = 16'h1234;
        tick();
        n_tests++;
        if (bus.pc !== 16'h1234) begin
            n_fail++;
            $display("FAIL reset_preload: pc=%h, want 1234", bus.pc);
        end
        // Assert reset between edges with a load pending.
        #2;
        bus.load_data = 16'h5555;
        rst_n         = 1'b0;
        #1;
        n_tests++;
        if (bus.pc !== 16'h0000 || bus.wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: pc=%h wrapped=%b, want pc=0000 wrapped=0",
                     bus.pc, bus.wrapped);
        end
        tick();
        n_tests++;
        if (bus.pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_held_edge: pc=%h, want 0000 (load aborted)", bus.pc);
        end
        #4;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.pc !== 16'h5555) begin
            n_fail++;
            $display("FAIL reset_release: pc=%h, want 5555", bus.pc);
        end
        idle_inputs();
    endtask

    task automatic test_increment();
        logic [15:0] exp_pc;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        n_tests++;
        if (bus.pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL inc_clear: pc=%h, want 0000", bus.pc);
        end
        bus.inc_en = 1'b1;
        bus.add_b  = 16'd16;
        bus.cin    = 1'b0;
        exp_pc     = 16'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (bus.next_pc !== exp_pc + 16'd16 || bus.cout !== 1'b0) begin
                n_fail++;
                $display("FAIL inc_next_pc[%0d]: next_pc=%h cout=%b, want %h 0",
                         i, bus.next_pc, bus.cout, exp_pc + 16'd16);
            end
            tick();
            exp_pc = exp_pc + 16'd16;
            n_tests++;
            if (bus.pc !== exp_pc || bus.wrapped !== 1'b0) begin
                n_fail++;
                $display("FAIL inc_pc[%0d]: pc=%h wrapped=%b, want %h 0",
                         i, bus.pc, bus.wrapped, exp_pc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        bus.load      = 1'b1;
        bus.load_data = 16'hFFF0;
        tick();
        bus.load   = 1'b0;
        bus.inc_en = 1'b1;
        bus.add_b  = 16'd16;
        #1;
        n_tests++;
        if (bus.cout !== 1'b1 || bus.next_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_comb: cout=%b next_pc=%h, want 1 0000", bus.cout, bus.next_pc);
        end
        tick();
        n_tests++;
`ifdef PC_SATURATE_EN
        if (bus.pc !== 16'hFFFF || bus.wrapped !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_edge: pc=%h wrapped=%b, want FFFF 1", bus.pc, bus.wrapped);
        end
`else
        if (bus.pc !== 16'h0000 || bus.wrapped !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_edge: pc=%h wrapped=%b, want 0000 1", bus.pc, bus.wrapped);
        end
`endif
        // Zero step: pc unchanged, wrapped cleared.
        bus.load      = 1'b1;
        bus.load_data = 16'h4321;
        tick();
        bus.load  = 1'b0;
        bus.add_b = 16'd16;
        bus.load_data = 16'hFFF0;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        tick();
        bus.add_b = 16'h0000;
        bus.cin   = 1'b0;
        tick();
        n_tests++;
        if (bus.wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_step_wrapped: wrapped=%b, want 0", bus.wrapped);
        end
`ifdef PC_SATURATE_EN
        if (bus.pc !== 16'hFFFF) begin
`else
        if (bus.pc !== 16'h0000) begin
`endif
            n_fail++;
            $display("FAIL zero_step_pc: pc=%h, want unchanged", bus.pc);
        end
        // Carry produced solely by cin.
        bus.load      = 1'b1;
        bus.load_data = 16'hFFFF;
        tick();
        bus.load = 1'b0;
        bus.cin  = 1'b1;
        #1;
        n_tests++;
        if (bus.next_pc !== 16'h0000 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL cin_carry: next_pc=%h cout=%b, want 0000 1", bus.next_pc, bus.cout);
        end
        idle_inputs();
    endtask

    task automatic test_load_priority();
        // Leave wrapped set so the load visibly clears it.
        bus.load      = 1'b1;
        bus.load_data = 16'hFFF0;
        tick();
        bus.load   = 1'b0;
        bus.inc_en = 1'b1;
        bus.add_b  = 16'd16;
        tick();
        bus.load      = 1'b1;
        bus.load_data = 16'hA5A0;
        tick();
        n_tests++;
        if (bus.pc !== 16'hA5A0 || bus.wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_inc: pc=%h wrapped=%b, want A5A0 0", bus.pc, bus.wrapped);
        end
        bus.clr       = 1'b1;
        bus.load_data = 16'h7777;
        tick();
        n_tests++;
        if (bus.pc !== 16'h0000 || bus.wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_over_load: pc=%h wrapped=%b, want 0000 0", bus.pc, bus.wrapped);
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        bus.load      = 1'b1;
        bus.load_data = 16'hFFF8;
        tick();
        bus.load   = 1'b0;
        bus.inc_en = 1'b1;
        bus.add_b  = 16'h0010;
        tick();
        // pc now 0008 (or FFFF saturated) with wrapped=1; must hold both.
        bus.inc_en = 1'b0;
        bus.add_b  = 16'h0100;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (bus.next_pc !== bus.pc || bus.cout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_comb[%0d]: next_pc=%h cout=%b, want pc=%h 0",
                         i, bus.next_pc, bus.cout, bus.pc);
            end
            tick();
            n_tests++;
`ifdef PC_SATURATE_EN
            if (bus.pc !== 16'hFFFF || bus.wrapped !== 1'b1) begin
`else
            if (bus.pc !== 16'h0008 || bus.wrapped !== 1'b1) begin
`endif
                n_fail++;
                $display("FAIL hold_pc[%0d]: pc=%h wrapped=%b, want held value and 1",
                         i, bus.pc, bus.wrapped);
            end
        end
        idle_inputs();
    endtask

    task automatic test_odd_operands();
        bus.load      = 1'b1;
        bus.load_data = 16'h0001;
        tick();
        bus.load   = 1'b0;
        bus.inc_en = 1'b1;
        bus.add_b  = 16'h7FFF;
        bus.cin    = 1'b1;
        #1;
        n_tests++;
        if (bus.next_pc !== 16'h8001 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_comb: next_pc=%h cout=%b, want 8001 0", bus.next_pc, bus.cout);
        end
        tick();
        n_tests++;
        if (bus.pc !== 16'h8001 || bus.wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_edge: pc=%h wrapped=%b, want 8001 0", bus.pc, bus.wrapped);
        end
        // Alternating bit patterns exercise every carry position.
        bus.add_b = 16'h5555;
        bus.cin   = 1'b0;
        #1;
        n_tests++;
        if (bus.next_pc !== 16'hD556 || bus.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern_comb: next_pc=%h cout=%b, want D556 0",
                     bus.next_pc, bus.cout);
        end
        bus.add_b = 16'hAAAA;
        bus.cin   = 1'b1;
        #1;
        n_tests++;
        if (bus.next_pc !== 16'h2AAC || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL pattern_carry: next_pc=%h cout=%b, want 2AAC 1",
                     bus.next_pc, bus.cout);
        end
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_increment();
        test_wrap();
        test_load_priority();
        test_hold();
        test_odd_operands();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
